// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath and the pipeline sequencer.
// master = datapath (drives ID-stage decode fields and branch resolution),
// slave  = pipe_hazard_ctrl (drives stall/flush/forward controls).
interface pipe_hazard_ctrl_if #(
    parameter int RSIZE = 4
);
    // Handshake: id_valid qualifies every id_* field in the same cycle. There is
    // no separate ready; pc_hold/ifid_hold are the back-pressure. While they are
    // 1 the datapath must present the same ID instruction again next cycle.
    logic             id_valid;
    logic [RSIZE-1:0] id_rs1;
    logic             id_use_rs1;
    logic [RSIZE-1:0] id_rs2;
    logic             id_use_rs2;
    logic             id_wr_en;
    logic [RSIZE-1:0] id_wr_addr;
    logic             id_is_load;
    logic             id_halt;
    logic             ex_br_taken;

    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_bubble;
    logic             flush;
    logic [1:0]       fwd_sel_a;
    logic [1:0]       fwd_sel_b;
    logic             halted;
    logic [15:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2,
               id_wr_en, id_wr_addr, id_is_load, id_halt, ex_br_taken,
        input  pc_hold, ifid_hold, idex_bubble, flush,
               fwd_sel_a, fwd_sel_b, halted, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2,
               id_wr_en, id_wr_addr, id_is_load, id_halt, ex_br_taken,
        output pc_hold, ifid_hold, idex_bubble, flush,
               fwd_sel_a, fwd_sel_b, halted, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 16-bit datapath: RAW scoreboard, branch squash,
// HALT drain. Optional macro PIPE_FORWARD_EN enables EX/MEM forwarding, so
// that only a load-use pair stalls. DEPTH must be at least 2.
module pipe_hazard_ctrl #(
    parameter int RSIZE        = 4,
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int R0_HARDWIRED = 1
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus,
    output logic [1:0]       dbg_state,
    output logic [DEPTH-1:0] dbg_sb_valid,
    output logic [DEPTH-1:0] dbg_sb_load
);
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] FC_INIT = 8'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [7:0]       flush_cnt;
    logic [DEPTH-1:0] sb_v;
    logic [DEPTH-1:0] sb_l;
    logic [RSIZE-1:0] sb_a [DEPTH];
    logic [15:0]      stall_cnt;

    logic [DEPTH-1:0] hit_a, hit_b;
    logic             haz_match, hazard, br, halt_trig, hold_drain;
    logic             flush_c, hold_c, bubble_c, issue, drain_done_next;
    logic [1:0]       fwd_a_c, fwd_b_c;

    // Source-vs-scoreboard compare; r0 never matches when hardwired.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a[i] = bus.id_use_rs1 && sb_v[i] && (sb_a[i] == bus.id_rs1) &&
                       !((R0_HARDWIRED != 0) && (bus.id_rs1 == '0));
            hit_b[i] = bus.id_use_rs2 && sb_v[i] && (sb_a[i] == bus.id_rs2) &&
                       !((R0_HARDWIRED != 0) && (bus.id_rs2 == '0));
        end
    end

`ifdef PIPE_FORWARD_EN
    // Only a load still in EX cannot be forwarded; the youngest producer wins.
    always_comb begin
        haz_match = (hit_a[0] || hit_b[0]) && sb_l[0];
        fwd_a_c   = 2'd0;
        fwd_b_c   = 2'd0;
        if (bus.id_valid) begin
            if (hit_a[0])      fwd_a_c = 2'd1;
            else if (hit_a[1]) fwd_a_c = 2'd2;
            if (hit_b[0])      fwd_b_c = 2'd1;
            else if (hit_b[1]) fwd_b_c = 2'd2;
        end
    end
`else
    // No bypass network: any in-flight producer stalls ID until it retires.
    always_comb begin
        haz_match = |(hit_a | hit_b);
        fwd_a_c   = 2'd0;
        fwd_b_c   = 2'd0;
    end
`endif

    // Per-cycle control decode from state, scoreboard and the ID/EX inputs.
    always_comb begin
        hazard     = (state == S_RUN) && bus.id_valid && haz_match;
        // An older taken branch wins over stalls and over a pending HALT.
        br         = bus.ex_br_taken && ((state == S_RUN) || (state == S_DRAIN));
        halt_trig  = (state == S_RUN) && bus.id_valid && bus.id_halt && !hazard && !br;
        hold_drain = !br && ((state == S_DRAIN) || (state == S_HALT) || halt_trig);
        // Gated by rst so every control reads 0 while reset is held.
        flush_c    = !rst && (br || (state == S_FLUSH));
        hold_c     = !rst && !flush_c && (hazard || hold_drain);
        bubble_c   = !rst && (flush_c || hazard || hold_drain);
        issue      = (state == S_RUN) && bus.id_valid && bus.id_wr_en && !hazard && !br &&
                     !((R0_HARDWIRED != 0) && (bus.id_wr_addr == '0));
        // Entries 0..DEPTH-2 empty means the pipe is empty after the next shift.
        drain_done_next = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (sb_v[i]) drain_done_next = 1'b0;
        end
    end

    assign bus.pc_hold     = hold_c;
    assign bus.ifid_hold   = hold_c;
    assign bus.idex_bubble = bubble_c;
    assign bus.flush       = flush_c;
    assign bus.fwd_sel_a   = fwd_a_c;
    assign bus.fwd_sel_b   = fwd_b_c;
    assign bus.halted      = (state == S_HALT);
    assign bus.stall_count = stall_cnt;
    assign dbg_state       = state;
    assign dbg_sb_valid    = sb_v;
    assign dbg_sb_load     = sb_l;

    // Sequencer state: RUN / FLUSH countdown / DRAIN / terminal HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            flush_cnt <= 8'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (br) begin
                        if (FLUSH_CYCLES > 1) begin
                            state     <= S_FLUSH;
                            flush_cnt <= FC_INIT;
                        end
                    end else if (halt_trig) begin
                        state <= drain_done_next ? S_HALT : S_DRAIN;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt <= 8'd1) begin
                        state     <= S_RUN;
                        flush_cnt <= 8'd0;
                    end else begin
                        flush_cnt <= flush_cnt - 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (br) begin
                        if (FLUSH_CYCLES > 1) begin
                            state     <= S_FLUSH;
                            flush_cnt <= FC_INIT;
                        end else begin
                            state <= S_RUN;
                        end
                    end else if (drain_done_next) begin
                        state <= S_HALT;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_RUN;
            endcase
        end
    end

    // Scoreboard shift: EX -> MEM -> WB, new entry only when ID really issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v <= '0;
            sb_l <= '0;
            for (int i = 0; i < DEPTH; i++) sb_a[i] <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_v[i] <= sb_v[i-1];
                sb_l[i] <= sb_l[i-1];
                sb_a[i] <= sb_a[i-1];
            end
            sb_v[0] <= issue;
            sb_l[0] <= issue && bus.id_is_load;
            sb_a[0] <= issue ? bus.id_wr_addr : '0;
        end
    end

    // Saturating count of non-flush bubble cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (bubble_c && !flush_c && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW stalls, r0, load-use, branch squash,
// HALT drain and asynchronous reset. Expectations follow PIPE_FORWARD_EN.
module tb_pipe_hazard_ctrl;
    localparam int RSIZE = 4;
    localparam int DEPTH = 3;
`ifdef PIPE_FORWARD_EN
    localparam int NB1 = 0, FWD1 = 1, NB2 = 1, FWD2 = 2;
`else
    localparam int NB1 = 3, FWD1 = 0, NB2 = 3, FWD2 = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0]       dbg_state;
    logic [DEPTH-1:0] dbg_sb_valid;
    logic [DEPTH-1:0] dbg_sb_load;
    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    pipe_hazard_ctrl_if #(.RSIZE(RSIZE)) bus ();

    pipe_hazard_ctrl #(
        .RSIZE(RSIZE), .DEPTH(DEPTH), .FLUSH_CYCLES(2), .R0_HARDWIRED(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .dbg_state(dbg_state), .dbg_sb_valid(dbg_sb_valid), .dbg_sb_load(dbg_sb_load)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic set_id(input logic v, input logic [3:0] rs1, input logic u1,
                          input logic [3:0] rs2, input logic u2, input logic wr,
                          input logic [3:0] wa, input logic ld, input logic hlt);
        bus.id_valid   = v;
        bus.id_rs1     = rs1;
        bus.id_use_rs1 = u1;
        bus.id_rs2     = rs2;
        bus.id_use_rs2 = u2;
        bus.id_wr_en   = wr;
        bus.id_wr_addr = wa;
        bus.id_is_load = ld;
        bus.id_halt    = hlt;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {pc_hold, ifid_hold, idex_bubble, flush, halted}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {11'd0, bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.flush, bus.halted},
            {11'd0, exp});
    endtask

    task automatic idle_cycles(input string tag, input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            #2; chk_ctl(tag, 5'b00000); @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ex_br_taken = 1'b0;
        idle();
        #2;
        chk_ctl("reset_ctl", 5'b00000);
        chk("reset_cnt", bus.stall_count, 16'd0);
        chk("reset_state", {14'd0, dbg_state}, 16'd0);
        chk("reset_fwd", {12'd0, bus.fwd_sel_a, bus.fwd_sel_b}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD r1,r2,r3 then ADD r2,r1,r3
        set_id(1, 2, 1, 3, 1, 1, 1, 0, 0);
        #2; chk_ctl("t1_add_r1", 5'b00000); @(negedge clk);
        set_id(1, 1, 1, 3, 1, 1, 2, 0, 0);
        for (int i = 0; i < NB1; i++) begin
            #2; chk_ctl("t1_raw_stall", 5'b11100);
            chk("t1_cnt_run", bus.stall_count, 16'(exp_cnt));
            exp_cnt++;
            @(negedge clk);
        end
        #2;
        chk_ctl("t1_issue", 5'b00000);
        chk("t1_fwd_a", {14'd0, bus.fwd_sel_a}, 16'(FWD1));
        chk("t1_fwd_b", {14'd0, bus.fwd_sel_b}, 16'd0);
        chk("t1_cnt", bus.stall_count, 16'(NB1));
        @(negedge clk);
        idle_cycles("t1_idle", 3);

        // ADD r0 then read r0 twice: never tracked
        set_id(1, 0, 0, 0, 0, 1, 0, 0, 0);
        #2; chk_ctl("t4_add_r0", 5'b00000); @(negedge clk);
        set_id(1, 0, 1, 0, 1, 1, 7, 0, 0);
        #2;
        chk_ctl("t4_use_r0", 5'b00000);
        chk("t4_sb", {13'd0, dbg_sb_valid}, 16'd0);
        chk("t4_fwd", {12'd0, bus.fwd_sel_a, bus.fwd_sel_b}, 16'd0);
        @(negedge clk);
        idle_cycles("t4_idle", 3);

        // LW r4 then ADD r5,r4,r4
        set_id(1, 0, 0, 0, 0, 1, 4, 1, 0);
        #2; chk_ctl("t2_lw", 5'b00000); @(negedge clk);
        chk("t2_sb_load", {13'd0, dbg_sb_load}, 16'd1);
        set_id(1, 4, 1, 4, 1, 1, 5, 0, 0);
        for (int i = 0; i < NB2; i++) begin
            #2; chk_ctl("t2_load_use", 5'b11100); exp_cnt++; @(negedge clk);
        end
        #2;
        chk_ctl("t2_issue", 5'b00000);
        chk("t2_fwd_a", {14'd0, bus.fwd_sel_a}, 16'(FWD2));
        chk("t2_fwd_b", {14'd0, bus.fwd_sel_b}, 16'(FWD2));
        chk("t2_cnt", bus.stall_count, 16'(exp_cnt));
        @(negedge clk);
        idle_cycles("t2_idle", 3);

        // LW r1, ADD r2,r1 stalls, taken branch arrives during the stall
        set_id(1, 0, 0, 0, 0, 1, 1, 1, 0);
        #2; chk_ctl("t3_lw", 5'b00000); @(negedge clk);
        set_id(1, 1, 1, 0, 0, 1, 2, 0, 0);
        #2; chk_ctl("t3_stall", 5'b11100); exp_cnt++; @(negedge clk);
        bus.ex_br_taken = 1'b1;
        #2; chk_ctl("t3_br", 5'b00110); @(negedge clk);
        bus.ex_br_taken = 1'b0;
        #2;
        chk_ctl("t3_flush2", 5'b00110);
        chk("t3_state", {14'd0, dbg_state}, 16'd1);
        chk("t3_sb", {13'd0, dbg_sb_valid}, 16'b100);
        @(negedge clk);
        idle();
        #2;
        chk_ctl("t3_after", 5'b00000);
        chk("t3_state_run", {14'd0, dbg_state}, 16'd0);
        chk("t3_cnt", bus.stall_count, 16'(exp_cnt));
        @(negedge clk);

        // LW r6 then HALT: 3 drain cycles, then halted
        set_id(1, 0, 0, 0, 0, 1, 6, 1, 0);
        #2; chk_ctl("t5_lw", 5'b00000); @(negedge clk);
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #2; chk_ctl("t5_drain", 5'b11100);
            chk("t5_drain_state", {14'd0, dbg_state}, (i == 0) ? 16'd0 : 16'd2);
            exp_cnt++;
            @(negedge clk);
        end
        #2;
        chk_ctl("t5_halted", 5'b11101);
        chk("t5_state", {14'd0, dbg_state}, 16'd3);
        chk("t5_cnt", bus.stall_count, 16'(exp_cnt));
        @(negedge clk);
        #2;
        chk_ctl("t5_halted2", 5'b11101);
        idle();
        #1; rst = 1'b1;
        #1;
        chk_ctl("t5_rst_ctl", 5'b00000);
        chk("t5_rst_state", {14'd0, dbg_state}, 16'd0);
        chk("t5_rst_cnt", bus.stall_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;

        // async reset in the middle of FLUSH
        set_id(1, 0, 0, 0, 0, 1, 3, 1, 0);
        #2; chk_ctl("t6_lw", 5'b00000); @(negedge clk);
        set_id(1, 3, 1, 0, 0, 1, 4, 0, 0);
        #2; chk_ctl("t6_stall", 5'b11100); @(negedge clk);
        bus.ex_br_taken = 1'b1;
        #2; chk_ctl("t6_br", 5'b00110); @(negedge clk);
        bus.ex_br_taken = 1'b0;
        #2;
        chk_ctl("t6_flush", 5'b00110);
        chk("t6_cnt_pre", bus.stall_count, 16'd1);
        #1; rst = 1'b1;
        #1;
        chk_ctl("t6_rst_ctl", 5'b00000);
        chk("t6_rst_state", {14'd0, dbg_state}, 16'd0);
        chk("t6_rst_cnt", bus.stall_count, 16'd0);
        chk("t6_rst_sb", {13'd0, dbg_sb_valid}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_ctl("t6_run", 5'b00000);
        chk("t6_run_state", {14'd0, dbg_state}, 16'd0);
        @(negedge clk);
        idle_cycles("t6_idle", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
